// File: rtl/windowed_const_mac.sv
// windowed_const_mac: scales each accepted sample by a constant and sums
// WIN scaled samples into one result, with optional saturation of the sum.
// A sticky flag remembers any overflow seen inside the window. A clear
// input flushes a partially filled window.
module windowed_const_mac #(
    parameter int IN_W     = 4,
    parameter int COEFF    = 25,
    parameter int COEFF_W  = 5,
    parameter int WIN      = 4,
    parameter int ACC_W    = 13,
    parameter int SATURATE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [IN_W-1:0]            in_x,
    input  logic                       clear,
    output logic                       out_valid,
    output logic [ACC_W-1:0]           out_sum,
    output logic                       overflow,
    output logic                       busy,
    output logic [$clog2(WIN+1)-1:0]   count
);

    localparam int P_W   = IN_W + COEFF_W;
    localparam int SUM_W = ACC_W + 1;
    localparam int CNT_W = $clog2(WIN + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sticky_q;
    logic [ACC_W-1:0]   out_sum_q;
    logic               ovf_q;
    logic               out_valid_q;

    logic [P_W-1:0]     prod_d;
    logic [SUM_W-1:0]   sum_d;
    logic               ovf_step_d;
    logic [ACC_W-1:0]   acc_d;
    logic               last_d;

    // Keeps the low ACC_W bits of the wide sum, or pins to full scale when
    // clamping is enabled and this step overflowed.
    function automatic logic [ACC_W-1:0] limit_acc(input logic [SUM_W-1:0] s,
                                                    input logic ovf);
        if ((SATURATE != 0) && ovf) begin
            return ACC_MAX;
        end
        return s[ACC_W-1:0];
    endfunction

    // Datapath for one accept: product, widened add, overflow step and the
    // resulting accumulator value.
    always_comb begin
        prod_d     = P_W'(in_x) * P_W'(COEFF);
        sum_d      = {1'b0, acc_q} + SUM_W'(prod_d);
        ovf_step_d = sum_d[ACC_W];
        // A clamped accumulator cannot grow further, so any non-zero
        // product on top of it is an overflow even though no carry appears.
        if ((SATURATE != 0) && (acc_q == ACC_MAX) && (prod_d != '0)) begin
            ovf_step_d = 1'b1;
        end
        acc_d  = limit_acc(sum_d, ovf_step_d);
        last_d = (cnt_q == LAST_CNT);
    end

    // Window FSM: accumulates accepted samples, publishes the result on the
    // WIN-th accept and restarts immediately; clear takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            out_sum_q   <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (clear) begin
                state_q  <= IDLE;
                acc_q    <= '0;
                cnt_q    <= '0;
                sticky_q <= 1'b0;
            end else if (in_valid) begin
                if (last_d) begin
                    out_sum_q   <= acc_d;
                    ovf_q       <= sticky_q | ovf_step_d;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    sticky_q    <= 1'b0;
                end else begin
                    state_q  <= ACCUM;
                    acc_q    <= acc_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    sticky_q <= sticky_q | ovf_step_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q == ACCUM);
    assign count     = cnt_q;

endmodule

// File: tb/tb_windowed_const_mac.sv
// Bench for windowed_const_mac: four configurations driven by the same
// stimulus and compared against a window-level arithmetic model.
module tb_windowed_const_mac;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_x;
    logic       clear;

    logic        ov0, ov1, ov2, ov3;
    logic [12:0] os0;
    logic [9:0]  os1, os2;
    logic [7:0]  os3;
    logic        of0, of1, of2, of3;
    logic        b0, b1, b2, b3;
    logic [2:0]  c0, c1, c2;
    logic [0:0]  c3;

    int checks = 0;
    int errors = 0;

    // configuration table: accumulator width, window length, clamp mode
    int p_acc[4] = '{13, 10, 10, 8};
    int p_win[4] = '{4, 4, 4, 1};
    int p_sat[4] = '{0, 1, 0, 1};

    // model: running true (unbounded) sum and sample count per window
    int m_s[4];
    int m_n[4];
    int m_sum[4];
    int m_ovf[4];
    int m_vld[4];

    always #5 clk = ~clk;

    windowed_const_mac u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .clear(clear),
        .out_valid(ov0), .out_sum(os0), .overflow(of0), .busy(b0), .count(c0));

    windowed_const_mac #(.ACC_W(10), .SATURATE(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .clear(clear),
        .out_valid(ov1), .out_sum(os1), .overflow(of1), .busy(b1), .count(c1));

    windowed_const_mac #(.ACC_W(10), .SATURATE(0)) u2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .clear(clear),
        .out_valid(ov2), .out_sum(os2), .overflow(of2), .busy(b2), .count(c2));

    windowed_const_mac #(.ACC_W(8), .WIN(1), .SATURATE(1)) u3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .clear(clear),
        .out_valid(ov3), .out_sum(os3), .overflow(of3), .busy(b3), .count(c3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_s[i] = 0; m_n[i] = 0; m_sum[i] = 0; m_ovf[i] = 0; m_vld[i] = 0;
        end
    endtask

    task automatic model_edge(input logic v, input int x, input logic c);
        int mx;
        for (int i = 0; i < 4; i++) begin
            m_vld[i] = 0;
            if (c) begin
                m_s[i] = 0;
                m_n[i] = 0;
            end else if (v) begin
                m_s[i] += x * 25;
                m_n[i]++;
                if (m_n[i] == p_win[i]) begin
                    mx = (1 << p_acc[i]) - 1;
                    if (p_sat[i] != 0) m_sum[i] = (m_s[i] > mx) ? mx : m_s[i];
                    else               m_sum[i] = m_s[i] % (mx + 1);
                    m_ovf[i] = (m_s[i] > mx) ? 1 : 0;
                    m_vld[i] = 1;
                    m_s[i] = 0;
                    m_n[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] vo[4], so[4], fo[4], bo[4], co[4];
        vo = '{32'(ov0), 32'(ov1), 32'(ov2), 32'(ov3)};
        so = '{32'(os0), 32'(os1), 32'(os2), 32'(os3)};
        fo = '{32'(of0), 32'(of1), 32'(of2), 32'(of3)};
        bo = '{32'(b0), 32'(b1), 32'(b2), 32'(b3)};
        co = '{32'(c0), 32'(c1), 32'(c2), 32'(c3)};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.u%0d.out_valid", tag, i), vo[i], 32'(m_vld[i]));
            chk($sformatf("%s.u%0d.out_sum", tag, i), so[i], 32'(m_sum[i]));
            chk($sformatf("%s.u%0d.overflow", tag, i), fo[i], 32'(m_ovf[i]));
            chk($sformatf("%s.u%0d.busy", tag, i), bo[i], 32'(m_n[i] > 0));
            chk($sformatf("%s.u%0d.count", tag, i), co[i], 32'(m_n[i]));
        end
    endtask

    // drive one edge worth of inputs, advance the model, check after the edge
    task automatic step(input string tag, input logic v, input int x, input logic c);
        in_valid = v;
        in_x     = 4'(x);
        clear    = c;
        @(posedge clk);
        model_edge(v, x, c);
        #1;
        check_all(tag);
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_x     = '0;
        clear    = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #2 check_all("por");
        repeat (2) @(posedge clk);
        #1 check_all("por_hold");
        reset = 1'b0;

        // first window: 10,5,12,1 -> 700
        step("tp1", 1'b1, 10, 1'b0);
        step("tp1", 1'b1, 5, 1'b0);
        step("tp1", 1'b1, 12, 1'b0);
        step("tp1", 1'b1, 1, 1'b0);
        chk("tp1_sum_const", 32'(os0), 32'd700);
        chk("tp1_ovf_const", 32'(of0), 32'd0);
        step("tp1_idle", 1'b0, 0, 1'b0);

        // back-to-back windows, full-scale samples then 1..4
        for (int k = 0; k < 4; k++) step("tp2a", 1'b1, 15, 1'b0);
        chk("tp2_sum1500", 32'(os0), 32'd1500);
        chk("tp3_sat1023", 32'(os1), 32'd1023);
        chk("tp3_satovf", 32'(of1), 32'd1);
        chk("tp4_wrap476", 32'(os2), 32'd476);
        chk("tp4_wrapovf", 32'(of2), 32'd1);
        for (int k = 1; k <= 4; k++) step("tp2b", 1'b1, k, 1'b0);
        chk("tp2_sum250", 32'(os0), 32'd250);
        for (int k = 0; k < 4; k++) step("tp3b", 1'b1, 1, 1'b0);
        chk("tp3_sum100", 32'(os1), 32'd100);
        chk("tp3_ovf0", 32'(of1), 32'd0);

        // clear beats a concurrent valid sample
        step("tp5", 1'b1, 10, 1'b0);
        step("tp5", 1'b1, 5, 1'b0);
        step("tp5_clr", 1'b1, 9, 1'b1);
        for (int k = 0; k < 4; k++) step("tp5b", 1'b1, 1, 1'b0);
        chk("tp5_sum100", 32'(os0), 32'd100);

        // async reset mid-window
        step("tp6", 1'b1, 10, 1'b0);
        step("tp6", 1'b1, 5, 1'b0);
        step("tp6", 1'b1, 12, 1'b0);
        async_reset("tp6_rst");
        for (int k = 0; k < 4; k++) step("tp6b", 1'b1, 2, 1'b0);
        chk("tp6_sum200", 32'(os0), 32'd200);

        // randomized traffic with gaps, clears and occasional resets
        for (int n = 0; n < 400; n++) begin
            logic v, c;
            int x;
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 19) == 0);
            x = $urandom_range(0, 15);
            step("rnd", v, x, c);
            if ($urandom_range(0, 79) == 0) async_reset("rnd_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
